pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_if.sv | 40 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 23 ++
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding and field widths.
package pipeline_ctrl_pkg;

    localparam int REG_W  = 5;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_HALTED     = 2'd3
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the core datapath (master) and the pipeline controller (slave).
interface pipeline_ctrl_if #(parameter int CNT_BIT = 32);
    import pipeline_ctrl_pkg::*;

    logic [REG_W-1:0]   id_req_a;
    logic [REG_W-1:0]   id_req_b;
    logic               id_use_a;
    logic               id_use_b;
    logic               ex_load;
    logic [REG_W-1:0]   ex_req_w;
    logic               dm_access;
    logic               branch_taken;
    logic               wb_halt;

    logic               pc_en;
    logic               if_id_en;
    logic               id_ex_en;
    logic               ex_dm_en;
    logic               dm_wb_en;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               halted;
    logic [CNT_BIT-1:0] stall_cnt;
    logic [CNT_BIT-1:0] flush_cnt;

    modport master (
        output id_req_a, id_req_b, id_use_a, id_use_b, ex_load, ex_req_w,
               dm_access, branch_taken, wb_halt,
        input  pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
               if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_req_a, id_req_b, id_use_a, id_use_b, ex_load, ex_req_w,
               dm_access, branch_taken, wb_halt,
        output pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en,
               if_id_flush, id_ex_flush, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Purely combinational load-use hazard comparison; register 0 never creates a dependency.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_req_a,
    input  logic [REG_W-1:0] id_req_b,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_req_w,
    output logic             hazard
);

    logic dest_valid_s;
    logic match_a_s;
    logic match_b_s;

    assign dest_valid_s = ex_load && (ex_req_w != {REG_W{1'b0}});
    assign match_a_s    = id_use_a && (id_req_a == ex_req_w);
    assign match_b_s    = id_use_b && (id_req_b == ex_req_w);
    assign hazard       = dest_valid_s && (match_a_s || match_b_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes, multi-cycle memory
// waits and halt, with saturating stall and flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DM_LATENCY = 1,
    parameter int CNT_BIT    = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.slave bus
);

    localparam bit               USE_WAIT  = (DM_LATENCY > 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(DM_LATENCY - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_BIT-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_BIT-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard_s;
    logic pc_en_s, if_id_en_s, id_ex_en_s, ex_dm_en_s, dm_wb_en_s;
    logic if_id_flush_s, id_ex_flush_s;

    hazard_detect u_hazard (
        .id_req_a (bus.id_req_a),
        .id_req_b (bus.id_req_b),
        .id_use_a (bus.id_use_a),
        .id_use_b (bus.id_use_b),
        .ex_load  (bus.ex_load),
        .ex_req_w (bus.ex_req_w),
        .hazard   (hazard_s)
    );

    // Next-state and enable/flush decode
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        pc_en_s       = 1'b1;
        if_id_en_s    = 1'b1;
        id_ex_en_s    = 1'b1;
        ex_dm_en_s    = 1'b1;
        dm_wb_en_s    = 1'b1;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A taken branch squashes the dependent instruction, so it beats the stall.
                if (bus.branch_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else if (hazard_s) begin
                    pc_en_s       = 1'b0;
                    if_id_en_s    = 1'b0;
                    id_ex_flush_s = 1'b1;
                end else begin
                    pc_en_s = 1'b1;
                end
                if (USE_WAIT && bus.dm_access) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_LOAD;
                end else if (hazard_s && !bus.branch_taken) begin
                    state_d = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD_STALL: begin
                state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                pc_en_s    = 1'b0;
                if_id_en_s = 1'b0;
                id_ex_en_s = 1'b0;
                ex_dm_en_s = 1'b0;
                dm_wb_en_s = 1'b0;
                if (wait_q <= WAIT_W'(1)) begin
                    state_d = ST_RUN;
                    wait_d  = {WAIT_W{1'b0}};
                end else begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = wait_q - WAIT_W'(1);
                end
            end
            ST_HALTED: begin
                pc_en_s    = 1'b0;
                if_id_en_s = 1'b0;
                id_ex_en_s = 1'b0;
                ex_dm_en_s = 1'b0;
                dm_wb_en_s = 1'b0;
                state_d    = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = {WAIT_W{1'b0}};
            end
        endcase
        if (bus.wb_halt) begin
            state_d = ST_HALTED;
            wait_d  = {WAIT_W{1'b0}};
        end else begin
            wait_d = wait_d;
        end
    end

    // Saturating performance counter updates
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en_s && (state_q != ST_HALTED) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_BIT'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (if_id_flush_s && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_BIT'(1);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, wait counter and performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_q      <= {WAIT_W{1'b0}};
            stall_cnt_q <= {CNT_BIT{1'b0}};
            flush_cnt_q <= {CNT_BIT{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en_s;
    assign bus.if_id_en    = if_id_en_s;
    assign bus.id_ex_en    = id_ex_en_s;
    assign bus.ex_dm_en    = ex_dm_en_s;
    assign bus.dm_wb_en    = dm_wb_en_s;
    assign bus.if_id_flush = if_id_flush_s;
    assign bus.id_ex_flush = id_ex_flush_s;
    assign bus.halted      = (state_q == ST_HALTED);
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: two controllers (single-cycle memory / 32-bit counters and
// 4-cycle memory / 4-bit counters) share one stimulus stream and one behavioural model.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req_a, req_b, ex_req_w;
    logic       use_a, use_b, ex_load, dm_access, branch_taken, wb_halt;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_BIT(32)) if_a ();
    pipeline_ctrl_if #(.CNT_BIT(4))  if_b ();

    assign if_a.id_req_a = req_a;       assign if_b.id_req_a = req_a;
    assign if_a.id_req_b = req_b;       assign if_b.id_req_b = req_b;
    assign if_a.id_use_a = use_a;       assign if_b.id_use_a = use_a;
    assign if_a.id_use_b = use_b;       assign if_b.id_use_b = use_b;
    assign if_a.ex_load  = ex_load;     assign if_b.ex_load  = ex_load;
    assign if_a.ex_req_w = ex_req_w;    assign if_b.ex_req_w = ex_req_w;
    assign if_a.dm_access = dm_access;  assign if_b.dm_access = dm_access;
    assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken;
    assign if_a.wb_halt  = wb_halt;     assign if_b.wb_halt  = wb_halt;

    pipeline_ctrl #(.DM_LATENCY(1), .CNT_BIT(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    pipeline_ctrl #(.DM_LATENCY(4), .CNT_BIT(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    // {pc, if_id, id_ex, ex_dm, dm_wb, if_id_flush, id_ex_flush, halted}
    logic [7:0] act_a, act_b;
    assign act_a = {if_a.pc_en, if_a.if_id_en, if_a.id_ex_en, if_a.ex_dm_en, if_a.dm_wb_en,
                    if_a.if_id_flush, if_a.id_ex_flush, if_a.halted};
    assign act_b = {if_b.pc_en, if_b.if_id_en, if_b.id_ex_en, if_b.ex_dm_en, if_b.dm_wb_en,
                    if_b.if_id_flush, if_b.id_ex_flush, if_b.halted};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: remaining wait cycles, bubble-just-inserted flag, halted flag, counters
    int     lat    [2] = '{1, 4};
    longint maxc   [2] = '{64'hFFFF_FFFF, 64'd15};
    int     m_wait [2];
    bit     m_stl  [2];
    bit     m_hlt  [2];
    longint m_sc   [2];
    longint m_fc   [2];

    typedef struct {
        logic [4:0] ra, rb;
        logic       ua, ub, ld;
        logic [4:0] rw;
        logic       br;
        logic [4:0] en;
        logic [1:0] fl;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit hz_f();
        return ex_load && (ex_req_w != 5'd0) &&
               ((use_a && req_a == ex_req_w) || (use_b && req_b == ex_req_w));
    endfunction

    function automatic logic [7:0] exp_f(input int k);
        if (m_hlt[k])      return 8'b0000_0001;
        if (m_wait[k] > 0) return 8'b0000_0000;
        if (m_stl[k])      return 8'b1111_1000;
        if (branch_taken)  return 8'b1111_1110;
        if (hz_f())        return 8'b0011_1010;
        return 8'b1111_1000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_stl[k] = 1'b0; m_hlt[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] e;
        bit run;
        e = exp_f(k);
        run = !m_hlt[k] && (m_wait[k] == 0) && !m_stl[k];
        if (!e[7] && !m_hlt[k] && m_sc[k] < maxc[k]) m_sc[k]++;
        if (e[2] && m_fc[k] < maxc[k]) m_fc[k]++;
        if (wb_halt) begin
            m_hlt[k] = 1'b1; m_wait[k] = 0; m_stl[k] = 1'b0;
        end else if (m_hlt[k]) begin
            m_hlt[k] = 1'b1;
        end else if (m_wait[k] > 0) begin
            m_wait[k]--;
        end else if (m_stl[k]) begin
            m_stl[k] = 1'b0;
        end else if (run && dm_access && lat[k] > 1) begin
            m_wait[k] = lat[k] - 1;
        end else if (run && hz_f() && !branch_taken) begin
            m_stl[k] = 1'b1;
        end
    endtask

    task automatic idle();
        req_a = 5'd0; req_b = 5'd0; ex_req_w = 5'd0;
        use_a = 1'b0; use_b = 1'b0; ex_load = 1'b0;
        dm_access = 1'b0; branch_taken = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic half();
        @(negedge clk);
        chk("vec_a", 64'(act_a), 64'(exp_f(0)));
        chk("vec_b", 64'(act_b), 64'(exp_f(1)));
        chk("stall_a", 64'(if_a.stall_cnt), 64'(m_sc[0]));
        chk("flush_a", 64'(if_a.flush_cnt), 64'(m_fc[0]));
        chk("stall_b", 64'(if_b.stall_cnt), 64'(m_sc[1]));
        chk("flush_b", 64'(if_b.flush_cnt), 64'(m_fc[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic cyc();
        half();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    task automatic set_hazard();
        ex_load = 1'b1; ex_req_w = 5'd5; use_a = 1'b1; req_a = 5'd5;
    endtask

    initial begin
        int hc;
        tv[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 2'b00};
        tv[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'b00111, 2'b01};
        tv[2] = '{5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'b00111, 2'b01};
        tv[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'b11111, 2'b00};
        tv[4] = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'b11111, 2'b00};
        tv[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 5'b11111, 2'b00};
        tv[6] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'b11111, 2'b11};
        tv[7] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'b11111, 2'b11};
        tv[8] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 5'b11111, 2'b00};
        tv[9] = '{5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 5'b00111, 2'b01};

        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        half();
        chk("reset_en", 64'(act_a[7:3]), 64'h1F);
        chk("reset_flush_halt", 64'(act_a[2:0]), 64'h0);
        tick();

        for (int i = 0; i < 10; i++) begin
            do_reset();
            req_a = tv[i].ra; req_b = tv[i].rb; use_a = tv[i].ua; use_b = tv[i].ub;
            ex_load = tv[i].ld; ex_req_w = tv[i].rw; branch_taken = tv[i].br;
            half();
            chk($sformatf("tv%0d_en", i), 64'(act_a[7:3]), 64'(tv[i].en));
            chk($sformatf("tv%0d_flush", i), 64'(act_a[2:1]), 64'(tv[i].fl));
            tick();
            idle();
        end

        // Load-use: one bubble, then free-running
        do_reset(); set_hazard();
        half();
        chk("lu_pc_en", 64'(if_a.pc_en), 64'd0);
        chk("lu_idex_flush", 64'(if_a.id_ex_flush), 64'd1);
        tick(); idle();
        half();
        chk("lu_after_en", 64'(act_a[7:3]), 64'h1F);
        tick();
        half();
        chk("lu_stall_cnt", 64'(if_a.stall_cnt), 64'd1);
        tick();

        // Register 0 as load destination
        do_reset(); set_hazard(); ex_req_w = 5'd0; req_a = 5'd0;
        half();
        chk("r0_en", 64'(act_a[7:3]), 64'h1F);
        tick(); idle();
        half();
        chk("r0_stall_cnt", 64'(if_a.stall_cnt), 64'd0);
        tick();

        // Branch together with hazard
        do_reset(); set_hazard(); branch_taken = 1'b1;
        half();
        chk("br_hz_flush", 64'(act_a[2:1]), 64'h3);
        chk("br_hz_pc_en", 64'(if_a.pc_en), 64'd1);
        tick(); idle();
        half();
        chk("br_hz_flush_cnt", 64'(if_a.flush_cnt), 64'd1);
        chk("br_hz_stall_cnt", 64'(if_a.stall_cnt), 64'd0);
        tick();

        // Memory wait of DM_LATENCY-1 frozen cycles
        do_reset(); dm_access = 1'b1;
        cyc();
        dm_access = 1'b0;
        for (int i = 0; i < 3; i++) begin
            half();
            chk($sformatf("mw_frozen%0d", i), 64'(act_b[7:3]), 64'h0);
            tick();
        end
        half();
        chk("mw_resume_en", 64'(act_b[7:3]), 64'h1F);
        chk("mw_stall_cnt", 64'(if_b.stall_cnt), 64'd3);
        chk("mw_lat1_no_wait", 64'(if_a.stall_cnt), 64'd0);
        tick();

        // Halt during the second wait cycle, then held
        do_reset(); dm_access = 1'b1;
        cyc();
        dm_access = 1'b0;
        cyc();
        wb_halt = 1'b1;
        cyc();
        wb_halt = 1'b0;
        for (int i = 0; i < 100; i++) begin
            half();
            chk("halt_held", 64'(act_b), 64'h01);
            tick();
        end

        // Asynchronous reset mid-cycle while halted
        #2 rst = 1'b1;
        #1;
        chk("arst_vec", 64'(act_b), 64'hF8);
        chk("arst_cnt", 64'({if_b.stall_cnt, if_b.flush_cnt}), 64'h0);
        model_reset();
        rst = 1'b0;

        // Saturation of the 4-bit stall counter after 21 stall cycles
        for (int i = 0; i < 7; i++) begin
            dm_access = 1'b1;
            cyc();
            dm_access = 1'b0;
            repeat (3) cyc();
        end
        half();
        chk("sat_stall_b", 64'(if_b.stall_cnt), 64'd15);
        chk("sat_stall_a", 64'(if_a.stall_cnt), 64'd0);
        tick();

        // Randomized stimulus against the model
        hc = 0;
        for (int i = 0; i < 3000; i++) begin
            ex_load      = ($urandom_range(0, 1) == 0);
            ex_req_w     = 5'($urandom_range(0, 3));
            req_a        = 5'($urandom_range(0, 3));
            req_b        = 5'($urandom_range(0, 3));
            use_a        = ($urandom_range(0, 1) == 0);
            use_b        = ($urandom_range(0, 1) == 0);
            branch_taken = ($urandom_range(0, 7) == 0);
            dm_access    = ($urandom_range(0, 5) == 0);
            wb_halt      = ($urandom_range(0, 149) == 0);
            cyc();
            if (m_hlt[0]) hc++;
            if (hc > 4 || $urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                rst = 1'b0;
                hc = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
